shift_add_mult: RTL and testbench



---
 rtl/shift_add_pkg.sv | 17 +
 rtl/shift_add_step.sv | 25 ++
 rtl/shift_add_mult.sv | 102 ++++++++++
 tb/tb_shift_add_mult.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // One extra bit so the step counter never wraps for any WIDTH.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational shift-and-add iteration: conditional accumulate, shift operands.
module shift_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // Next-iteration datapath values
  always_comb begin
    acc_next    = acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-and-add step per clock, start/done handshake.
module shift_add_mult
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);

  state_e             state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] mcand_next_s;
  logic [WIDTH-1:0]   mplier_next_s;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc_r),
    .mcand       (mcand_r),
    .mplier      (mplier_r),
    .acc_next    (acc_next_s),
    .mcand_next  (mcand_next_s),
    .mplier_next (mplier_next_s)
  );

  // Control FSM, iteration counter and datapath/output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            acc_r    <= {(2*WIDTH){1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_next_s;
          mplier_r <= mplier_next_s;
          count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          busy_r   <= 1'b1;
          // Last step: publish the accumulator including this step's add.
          if (count_r == CW'(WIDTH - 1)) begin
            product_r <= acc_next_s;
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=4) with an expected-product scoreboard.
module tb_shift_add_mult;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];

  shift_add_mult #(.WIDTH(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one operation (accepted at the next edge) and wait for done; lat = edges after acceptance.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clock);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    exp_q.push_back({4'h0, a} * {4'h0, b});
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    multiplicand = 4'($urandom_range(0, 15));
    multiplier = 4'($urandom_range(0, 15));
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    multiplicand = 4'h0;
    multiplier = 4'h0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      $display("FAIL reset_state: busy=%b done=%b product=%h, expected 0/0/00", busy, done, product);
      n_fail++;
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      $display("FAIL reset_release: busy=%b done=%b product=%h, expected 0/0/00", busy, done, product);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    int busy_cycles;
    int done_cycles;
    logic [7:0] exp;
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b0011;
    multiplier = 4'b0101;
    exp_q.push_back(8'b0000_1111);
    busy_cycles = 0;
    done_cycles = 0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    multiplicand = 4'hF;
    multiplier = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        n_checks++;
        if (i !== 5) begin
          $display("FAIL basic_latency: done seen after edge k+%0d, expected k+4", i - 1);
          n_fail++;
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (product !== exp) begin
          $display("FAIL basic_product: got %b expected %b", product, exp);
          n_fail++;
        end
      end
      @(negedge clock);
    end
    n_checks++;
    if (busy_cycles !== 5) begin
      $display("FAIL basic_busy_len: busy %0d cycles expected 5", busy_cycles);
      n_fail++;
    end
    n_checks++;
    if (done_cycles !== 1) begin
      $display("FAIL basic_done_len: done %0d cycles expected 1", done_cycles);
      n_fail++;
    end
  endtask

  task automatic test_max();
    int lat;
    logic [7:0] exp;
    start_op(4'hF, 4'hF, lat);
    n_checks++;
    if (lat !== 4) begin
      $display("FAIL max_latency: got %0d expected 4", lat);
      n_fail++;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (product !== exp || product !== 8'd225) begin
      $display("FAIL max_product: got %0d expected 225", product);
      n_fail++;
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [7:0] exp;
    logic [3:0] ops [2][2];
    ops[0][0] = 4'b0000; ops[0][1] = 4'b1011;
    ops[1][0] = 4'b1011; ops[1][1] = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      start_op(ops[t][0], ops[t][1], lat);
      n_checks++;
      if (lat !== 4) begin
        $display("FAIL zero_latency[%0d]: got %0d expected 4", t, lat);
        n_fail++;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (product !== exp || product !== 8'h00) begin
        $display("FAIL zero_product[%0d]: got %b expected 00000000", t, product);
        n_fail++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    int done_edges [$];
    logic [7:0] exp;
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b0010;
    multiplier = 4'b0011;
    exp_q.push_back(8'b0000_0110);
    @(posedge clock);
    @(negedge clock);
    multiplicand = 4'b0100;
    multiplier = 4'b0100;
    exp_q.push_back(8'b0001_0000);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 6) start = 1'b0;
      if (e == 7) begin
        multiplicand = 4'hF;
        multiplier = 4'hF;
      end
      if (done) begin
        done_edges.push_back(e);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra_done: done at edge k+%0d with empty scoreboard", e);
          n_fail++;
        end else begin
          exp = exp_q.pop_front();
          if (product !== exp) begin
            $display("FAIL b2b_product: edge k+%0d got %b expected %b", e, product, exp);
            n_fail++;
          end
        end
      end
    end
    n_checks++;
    if (done_edges.size() !== 2) begin
      $display("FAIL b2b_done_count: got %0d expected 2", done_edges.size());
      n_fail++;
    end else begin
      n_checks++;
      if (done_edges[0] !== 4 || done_edges[1] !== 10) begin
        $display("FAIL b2b_done_edges: got k+%0d,k+%0d expected k+4,k+10", done_edges[0], done_edges[1]);
        n_fail++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen_done;
    logic [7:0] exp;
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b0111;
    multiplier = 4'b0111;
    exp_q.push_back(8'd49);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      $display("FAIL midreset_immediate: busy=%b done=%b product=%h expected 0/0/00", busy, done, product);
      n_fail++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done || busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0 || product !== 8'h00) begin
      $display("FAIL midreset_quiet: activity=%0d product=%h expected 0/00", seen_done, product);
      n_fail++;
    end
    start_op(4'b0010, 4'b0010, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 4 || product !== exp || product !== 8'b0000_0100) begin
      $display("FAIL midreset_rerun: lat=%0d product=%b expected 4/00000100", lat, product);
      n_fail++;
    end
  endtask

  task automatic test_done_start();
    int lat;
    int extra;
    logic [7:0] exp;
    start_op(4'b0011, 4'b0011, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 4 || product !== exp) begin
      $display("FAIL donestart_first: lat=%0d product=%0d expected 4/%0d", lat, product, exp);
      n_fail++;
    end
    // Now in the DONE cycle: pulse start, it must be ignored.
    start = 1'b1;
    multiplicand = 4'b0101;
    multiplier = 4'b0101;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd9) begin
      $display("FAIL donestart_ignored: busy=%b done=%b product=%0d expected 0/0/9", busy, done, product);
      n_fail++;
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0 || product !== 8'd9) begin
      $display("FAIL donestart_hold: activity=%0d product=%0d expected 0/9", extra, product);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_done_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
